fpadd_arbiter: RTL and testbench

Sequencing controller and arbiter that shares one floating-point adder between several requesters (e.g. integer core FAD/FSB, FLT/FLOOR path, vector helper). It accepts operations over a req/ack handshake, selects one requester, and drives the adder's run/u/v/x/y inputs for exactly one operation. It watches the adder's stall output, captures the result, and returns it with a one-cycle ack. It sits between the requesters and the adder instance; the adder itself is unchanged.

---
 rtl/fpadd_arb_pkg.sv | 30 +++
 rtl/fpadd_arb_pick.sv | 56 +++++
 rtl/fpadd_arbiter.sv | 156 +++++++++++++++
 tb/tb_fpadd_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_arb_pkg.sv
// Shared opcodes, FSM encoding and the float conversion constant for fpadd_arbiter.
package fpadd_arb_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_FLT   = 2'b01;
    localparam logic [1:0] OP_FLOOR = 2'b10;

    // 2^23 as single precision; adding it aligns integer bits for FLT/FLOOR
    localparam logic [31:0] FA_Y_CONV = 32'h4B00_0000;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } arb_state_e;

    function automatic int unsigned arb_idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Returns {u, v} adder mode selects; opcode 11 falls through to add.
    function automatic logic [1:0] conv_sel(logic [1:0] op);
        case (op)
            OP_FLT:   return 2'b10;
            OP_FLOOR: return 2'b01;
            default:  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/fpadd_arb_pick.sv
// Combinational winner select for fpadd_arbiter. FPADD_ARB_RR_EN selects round-robin
// starting after ptr; otherwise fixed priority with the lowest index winning.
module fpadd_arb_pick
    import fpadd_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]                  req,
`ifdef FPADD_ARB_RR_EN
    input  logic [arb_idx_w(NREQ)-1:0]       ptr,
`endif
    output logic                             gnt_vld,
    output logic [NREQ-1:0]                  gnt_oh,
    output logic [arb_idx_w(NREQ)-1:0]       gnt_idx
);

    localparam int unsigned IdxW = arb_idx_w(NREQ);

    assign gnt_vld = |req;

`ifdef FPADD_ARB_RR_EN
    int dist;
    int best_dist;

    // Distance 0 is the slot right after the last grant; smallest requesting distance wins.
    always_comb begin
        gnt_idx   = '0;
        dist      = 0;
        best_dist = int'(NREQ);
        for (int i = 0; i < int'(NREQ); i++) begin
            dist = (i + int'(NREQ) - 1 - int'(ptr)) % int'(NREQ);
            if (req[i] && (dist < best_dist)) begin
                best_dist = dist;
                gnt_idx   = IdxW'(i);
            end
        end
    end
`else
    always_comb begin
        gnt_idx = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_idx = IdxW'(i);
            end
        end
    end
`endif

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            gnt_oh[i] = gnt_vld && (gnt_idx == IdxW'(i));
        end
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Shares one floating-point adder between NREQ requesters over a req/ack handshake.
// Define FPADD_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module fpadd_arbiter
    import fpadd_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [32*NREQ-1:0]   a,
    input  logic [32*NREQ-1:0]   b,
    output logic [NREQ-1:0]      ack,
    output logic [31:0]          rdata,
    output logic                 busy,
    output logic                 fa_run,
    output logic                 fa_u,
    output logic                 fa_v,
    output logic [31:0]          fa_x,
    output logic [31:0]          fa_y,
    input  logic                 fa_stall,
    input  logic [31:0]          fa_z
);

    localparam int unsigned IdxW = arb_idx_w(NREQ);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] gidx_q;
    logic [1:0]      op_q;
    logic [31:0]     a_q, b_q;
    logic [31:0]     rdata_q;
    logic            run_q;

    logic            gnt_vld;
    logic [NREQ-1:0] gnt_oh;
    logic [IdxW-1:0] gnt_idx;
    logic [1:0]      sel_op;
    logic [31:0]     sel_a, sel_b;
    logic            load, capture;

`ifdef FPADD_ARB_RR_EN
    logic [IdxW-1:0] ptr_q;
`endif

    fpadd_arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req     (req),
`ifdef FPADD_ARB_RR_EN
        .ptr     (ptr_q),
`endif
        .gnt_vld (gnt_vld),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_oh[i]) begin
                sel_op = op[2*i +: 2];
                sel_a  = a[32*i +: 32];
                sel_b  = b[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_vld) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            // Latency is whatever the adder takes; no internal cycle count.
            StRun: begin
                if (!fa_stall) begin
                    capture = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= (state_d == StRun);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gidx_q <= '0;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
        end else if (load) begin
            gidx_q <= gnt_idx;
            op_q   <= sel_op;
            a_q    <= sel_a;
            b_q    <= sel_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= fa_z;
        end
    end

`ifdef FPADD_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= IdxW'(NREQ - 1);
        end else if (load) begin
            ptr_q <= gnt_idx;
        end
    end
`endif

    always_comb begin
        ack = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            ack[i] = (state_q == StDone) && (gidx_q == IdxW'(i));
        end
    end

    assign busy         = (state_q != StIdle);
    assign rdata        = rdata_q;
    assign fa_run       = run_q;
    assign {fa_u, fa_v} = conv_sel(op_q);
    assign fa_x         = a_q;
    assign fa_y         = (fa_u || fa_v) ? FA_Y_CONV : b_q;

    // Requester must hold req while its operation is in the adder.
    a_req_held: assert property (@(posedge clk) disable iff (!rst)
        (state_q == StRun) |-> req[gidx_q]);

    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(ack));

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Self-checking bench for fpadd_arbiter with a behavioural stall/result adder stub.
module tb_fpadd_arbiter;

    localparam int unsigned NREQ = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [2*NREQ-1:0]   op;
    logic [32*NREQ-1:0]  a;
    logic [32*NREQ-1:0]  b;
    logic [NREQ-1:0]     ack;
    logic [31:0]         rdata;
    logic                busy;
    logic                fa_run;
    logic                fa_u;
    logic                fa_v;
    logic [31:0]         fa_x;
    logic [31:0]         fa_y;
    logic                fa_stall;
    logic [31:0]         fa_z;

    int n_pass  = 0;
    int n_total = 0;
    int run_cnt;

    bit          r_req [NREQ];
    logic [1:0]  r_op  [NREQ];
    logic [31:0] r_a   [NREQ];
    logic [31:0] r_b   [NREQ];

    always #5 clk = ~clk;

    fpadd_arbiter #(
        .NREQ (NREQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op       (op),
        .a        (a),
        .b        (b),
        .ack      (ack),
        .rdata    (rdata),
        .busy     (busy),
        .fa_run   (fa_run),
        .fa_u     (fa_u),
        .fa_v     (fa_v),
        .fa_x     (fa_x),
        .fa_y     (fa_y),
        .fa_stall (fa_stall),
        .fa_z     (fa_z)
    );

    function automatic real sp2r(logic [31:0] s);
        int          e;
        logic [63:0] d;
        if (s[30:0] == 31'd0) return 0.0;
        e = int'(s[30:23]) - 127 + 1023;
        d = {s[31], e[10:0], s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(real r);
        int          e;
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Spec-level result of one operation as seen by the requester.
    function automatic logic [31:0] ref_result(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        case (o)
            2'b01:   return r2sp($itor($signed(x)));
            2'b10:   return 32'($rtoi($floor(sp2r(x))));
            default: return r2sp(sp2r(x) + sp2r(y));
        endcase
    endfunction

    function automatic logic [31:0] fa_model(logic [31:0] x, logic [31:0] y, logic u, logic v);
        if ((u || v) && (y != 32'h4B00_0000)) return 32'hBAD0_0000;
        if (u) return r2sp($itor($signed(x)));
        if (v) return 32'($rtoi($floor(sp2r(x))));
        return r2sp(sp2r(x) + sp2r(y));
    endfunction

    function automatic logic [31:0] rand_float();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 140)), 23'($urandom)};
    endfunction

    // Adder stub: stall released in the 4th consecutive run cycle; garbage while stalled.
    always @(posedge clk or negedge rst) begin
        if (!rst) run_cnt <= 0;
        else if (fa_run) run_cnt <= run_cnt + 1;
        else run_cnt <= 0;
    end
    assign fa_stall = fa_run && (run_cnt < 3);
    assign fa_z     = fa_stall ? 32'hDEAD_BEEF : fa_model(fa_x, fa_y, fa_u, fa_v);

    task automatic drive_bus();
        for (int i = 0; i < int'(NREQ); i++) begin
            req[i]          = r_req[i];
            op[2*i +: 2]    = r_op[i];
            a[32*i +: 32]   = r_a[i];
            b[32*i +: 32]   = r_b[i];
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < int'(NREQ); i++) begin
            r_req[i] = 1'b0;
            r_op[i]  = 2'b00;
            r_a[i]   = 32'd0;
            r_b[i]   = 32'd0;
        end
        drive_bus();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_reqs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_reqs();
        repeat (3) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (fa_run !== 1'b0) $display("FAIL reset_fa_run: got %b want 0", fa_run); else n_pass++;
        n_total++; if (ack !== '0) $display("FAIL reset_ack: got %b want 0", ack); else n_pass++;
        n_total++; if (rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", rdata); else n_pass++;
        n_total++; if ({fa_u, fa_v} !== 2'b00) $display("FAIL reset_uv: got %b want 00", {fa_u, fa_v}); else n_pass++;
        n_total++; if (fa_x !== 32'd0 || fa_y !== 32'd0)
            $display("FAIL reset_xy: got %h/%h want 0/0", fa_x, fa_y); else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL idle_no_req_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_single_op(string name, int idx, logic [1:0] o, logic [31:0] x,
                                  logic [31:0] y, logic [1:0] exp_uv, logic [31:0] exp_y,
                                  logic [31:0] exp_rd);
        logic [NREQ-1:0] exp_ack;
        exp_ack      = '0;
        exp_ack[idx] = 1'b1;
        r_req[idx] = 1'b1; r_op[idx] = o; r_a[idx] = x; r_b[idx] = y;
        drive_bus();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_total++; if (fa_run !== (c >= 1 && c <= 4))
                $display("FAIL %s_fa_run_c%0d: got %b want %b", name, c, fa_run, (c >= 1 && c <= 4));
            else n_pass++;
            if (c == 2) begin
                n_total++; if ({fa_u, fa_v} !== exp_uv)
                    $display("FAIL %s_uv: got %b want %b", name, {fa_u, fa_v}, exp_uv); else n_pass++;
                n_total++; if (fa_x !== x || fa_y !== exp_y)
                    $display("FAIL %s_xy: got %h/%h want %h/%h", name, fa_x, fa_y, x, exp_y);
                else n_pass++;
            end
            if (c == 5) begin
                n_total++; if (ack !== exp_ack)
                    $display("FAIL %s_ack: got %b want %b", name, ack, exp_ack); else n_pass++;
                n_total++; if (rdata !== exp_rd)
                    $display("FAIL %s_rdata: got %h want %h", name, rdata, exp_rd); else n_pass++;
                r_req[idx] = 1'b0;
                drive_bus();
            end
            if (c == 6) begin
                n_total++; if (busy !== 1'b0 || ack !== '0)
                    $display("FAIL %s_done: got busy %b ack %b want 0 0", name, busy, ack); else n_pass++;
                n_total++; if (rdata !== exp_rd)
                    $display("FAIL %s_rdata_hold: got %h want %h", name, rdata, exp_rd); else n_pass++;
            end
        end
    endtask

    task automatic test_contention();
        int              n_ack;
        logic [NREQ-1:0] exp_ack;
        logic [31:0]     exp_rd;
        do_reset();
        r_req[0] = 1'b1; r_op[0] = 2'b00; r_a[0] = 32'h3F80_0000; r_b[0] = 32'h4000_0000;
        r_req[1] = 1'b1; r_op[1] = 2'b01; r_a[1] = 32'h0000_0005; r_b[1] = 32'h1234_5678;
        drive_bus();
        n_ack = 0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (ack !== '0) begin
                exp_ack = '0;
`ifdef FPADD_ARB_RR_EN
                exp_ack[n_ack % 2] = 1'b1;
`else
                exp_ack[0] = 1'b1;
`endif
                exp_rd = exp_ack[0] ? 32'h4040_0000 : 32'h40A0_0000;
                n_total++; if (ack !== exp_ack)
                    $display("FAIL contention_ack%0d: got %b want %b", n_ack, ack, exp_ack); else n_pass++;
                n_total++; if (rdata !== exp_rd)
                    $display("FAIL contention_rdata%0d: got %h want %h", n_ack, rdata, exp_rd); else n_pass++;
                n_total++; if (c != 5 + 6 * n_ack)
                    $display("FAIL contention_cycle%0d: got %0d want %0d", n_ack, c, 5 + 6 * n_ack);
                else n_pass++;
                n_ack++;
                if (n_ack == 4) clear_reqs();
            end
        end
        n_total++; if (n_ack != 4) $display("FAIL contention_count: got %0d want 4", n_ack); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int gap;
        int rise_c;
        do_reset();
        r_req[0] = 1'b1; r_op[0] = 2'b00; r_a[0] = 32'h3F80_0000; r_b[0] = 32'h4000_0000;
        drive_bus();
        gap    = 0;
        rise_c = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c >= 5 && rise_c == 0) begin
                if (fa_run === 1'b1) rise_c = c;
                else gap++;
            end
            if (c == 5) begin
                n_total++; if (ack !== 2'b01 || rdata !== 32'h4040_0000)
                    $display("FAIL b2b_first: got ack %b rdata %h want 01 40400000", ack, rdata);
                else n_pass++;
                r_req[0] = 1'b0;
                drive_bus();
            end
            if (c == 6) begin
                r_req[0] = 1'b1; r_a[0] = 32'h3FC0_0000; r_b[0] = 32'h3E80_0000;
                drive_bus();
            end
            if (c == 11) begin
                n_total++; if (ack !== 2'b01 || rdata !== 32'h3FE0_0000)
                    $display("FAIL b2b_second: got ack %b rdata %h want 01 3fe00000", ack, rdata);
                else n_pass++;
                r_req[0] = 1'b0;
                drive_bus();
            end
        end
        n_total++; if (gap < 1 || gap > 2 || rise_c != 7)
            $display("FAIL b2b_run_gap: got gap %0d rise %0d want gap 1..2 rise 7", gap, rise_c);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        r_req[1] = 1'b1; r_op[1] = 2'b10; r_a[1] = 32'h4020_0000; r_b[1] = 32'h0;
        drive_bus();
        repeat (2) @(negedge clk);
        n_total++; if (fa_run !== 1'b1) $display("FAIL midrst_pre_run: got %b want 1", fa_run); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (fa_run !== 1'b0 || busy !== 1'b0)
            $display("FAIL midrst_run_busy: got %b %b want 0 0", fa_run, busy); else n_pass++;
        n_total++; if (ack !== '0 || rdata !== 32'd0)
            $display("FAIL midrst_ack_rdata: got %b %h want 0 0", ack, rdata); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            n_total++; if (fa_run !== (c <= 4))
                $display("FAIL midrst_fa_run_c%0d: got %b want %b", c, fa_run, (c <= 4)); else n_pass++;
            n_total++; if (ack !== ((c == 5) ? 2'b10 : 2'b00))
                $display("FAIL midrst_ack_c%0d: got %b", c, ack); else n_pass++;
            if (c == 5) begin
                n_total++; if (rdata !== 32'h0000_0002)
                    $display("FAIL midrst_rdata: got %h want 00000002", rdata); else n_pass++;
                r_req[1] = 1'b0;
                drive_bus();
            end
        end
    endtask

    task automatic test_random();
        bit              pend [NREQ];
        bit              inflight;
        bit              idle_now;
        bit              any_pend;
        int              age;
        int              win;
        int              last_g;
        int              cand;
        int              n_ops;
        logic [31:0]     held;
        logic [31:0]     exp_y;
        logic [NREQ-1:0] exp_ack;
        do_reset();
        for (int i = 0; i < int'(NREQ); i++) pend[i] = 1'b0;
        inflight = 1'b0; age = 0; win = 0; last_g = int'(NREQ) - 1; held = 32'd0; n_ops = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            if (inflight) age++;
            idle_now = !inflight;
            exp_ack  = '0;
            if (inflight && age == 5) exp_ack[win] = 1'b1;
            n_total++; if (busy !== inflight)
                $display("FAIL rand_busy@%0d: got %b want %b", cyc, busy, inflight); else n_pass++;
            n_total++; if (fa_run !== (inflight && age <= 4))
                $display("FAIL rand_run@%0d: got %b want %b", cyc, fa_run, inflight && age <= 4);
            else n_pass++;
            n_total++; if (ack !== exp_ack)
                $display("FAIL rand_ack@%0d: got %b want %b", cyc, ack, exp_ack); else n_pass++;
            if (inflight && age <= 4) begin
                exp_y = (r_op[win] == 2'b01 || r_op[win] == 2'b10) ? 32'h4B00_0000 : r_b[win];
                n_total++; if (fa_x !== r_a[win] || fa_y !== exp_y ||
                               {fa_u, fa_v} !== {r_op[win] == 2'b01, r_op[win] == 2'b10})
                    $display("FAIL rand_operands@%0d: got %h %h %b want %h %h op %b",
                             cyc, fa_x, fa_y, {fa_u, fa_v}, r_a[win], exp_y, r_op[win]);
                else n_pass++;
            end
            if (exp_ack != '0) begin
                held       = ref_result(r_op[win], r_a[win], r_b[win]);
                pend[win]  = 1'b0;
                r_req[win] = 1'b0;
                inflight   = 1'b0;
                n_ops++;
            end
            n_total++; if (rdata !== held)
                $display("FAIL rand_rdata@%0d: got %h want %h", cyc, rdata, held); else n_pass++;
            if (cyc < 500) begin
                for (int i = 0; i < int'(NREQ); i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i]  = 1'b1;
                        r_req[i] = 1'b1;
                        r_op[i]  = 2'($urandom_range(0, 3));
                        r_a[i]   = (r_op[i] == 2'b01) ? 32'($urandom_range(0, 200000)) - 32'd100000
                                                      : rand_float();
                        r_b[i]   = rand_float();
                    end
                end
            end
            drive_bus();
            any_pend = 1'b0;
            for (int i = 0; i < int'(NREQ); i++) any_pend |= pend[i];
            if (idle_now && any_pend) begin
`ifdef FPADD_ARB_RR_EN
                for (int k = 1; k <= int'(NREQ); k++) begin
                    cand = (last_g + k) % int'(NREQ);
                    if (pend[cand]) begin
                        win = cand;
                        break;
                    end
                end
`else
                for (int k = int'(NREQ) - 1; k >= 0; k--) begin
                    if (pend[k]) win = k;
                end
`endif
                last_g   = win;
                inflight = 1'b1;
                age      = 0;
            end
            if (cyc >= 500 && !inflight && !any_pend) break;
        end
        n_total++; if (inflight || any_pend)
            $display("FAIL rand_drain: got inflight %b pending %b want 0 0", inflight, any_pend);
        else n_pass++;
        n_total++; if (n_ops < 20) $display("FAIL rand_ops: got %0d want >= 20", n_ops); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        clear_reqs();
        test_reset();
        test_single_op("add", 0, 2'b00, 32'h3F80_0000, 32'h4000_0000, 2'b00, 32'h4000_0000,
                       32'h4040_0000);
        test_single_op("flt", 1, 2'b01, 32'h0000_0005, 32'hCAFE_F00D, 2'b10, 32'h4B00_0000,
                       32'h40A0_0000);
        test_single_op("floor", 0, 2'b10, 32'h4020_0000, 32'h1111_1111, 2'b01, 32'h4B00_0000,
                       32'h0000_0002);
        test_single_op("op11", 1, 2'b11, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 32'h3F80_0000,
                       32'h4000_0000);
        test_contention();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
